// File: rtl/compare_tally_if.sv
// compare_tally_if: flag-triple input handshake plus summary-record output handshake.
interface compare_tally_if #(
  parameter int CW = 16
) ();
  logic          in_valid;
  logic          in_ready;
  logic          lt;
  logic          et;
  logic          gt;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] lt_cnt;
  logic [CW-1:0] et_cnt;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] n_samples;
  logic [1:0]    verdict;

  // Producer of flag triples and consumer of summaries.
  modport master (
    output in_valid, lt, et, gt, flush, out_ready,
    input  in_ready, out_valid, lt_cnt, et_cnt, gt_cnt, err_cnt, n_samples, verdict
  );

  // The tally block itself.
  modport slave (
    input  in_valid, lt, et, gt, flush, out_ready,
    output in_ready, out_valid, lt_cnt, et_cnt, gt_cnt, err_cnt, n_samples, verdict
  );
endinterface

// File: rtl/compare_tally.sv
// compare_tally: counts comparator lt/et/gt outcomes over a window of samples
// and presents a held summary record (counts, malformed count, verdict).
module compare_tally #(
  parameter int WINDOW = 16,
  parameter int CW     = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  compare_tally_if.slave cmp_if
);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_WIN  = CW'(WINDOW);

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  // Dominant outcome: only a strict maximum wins; ties and all-zero give 00.
  function automatic logic [1:0] verdict_of(input logic [CW-1:0] a_lt,
                                            input logic [CW-1:0] a_et,
                                            input logic [CW-1:0] a_gt);
    if ((a_lt > a_et) && (a_lt > a_gt)) begin
      return 2'b01;
    end else if ((a_et > a_lt) && (a_et > a_gt)) begin
      return 2'b10;
    end else if ((a_gt > a_lt) && (a_gt > a_et)) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] lt_q, et_q, gt_q, err_q, n_q;
  logic [CW-1:0] lt_d, et_d, gt_d, err_d, n_d;
  logic [CW-1:0] lt_inc_s, et_inc_s, gt_inc_s, err_inc_s, n_inc_s;
  logic          accept_s, report_s;
  logic          is_lt_s, is_et_s, is_gt_s, is_err_s;

  logic          out_valid_q;
  logic [CW-1:0] lt_cnt_q, et_cnt_q, gt_cnt_q, err_cnt_q, n_samples_q;
  logic [1:0]    verdict_q;

  // Reset forces in_ready low even before the state register settles.
  assign cmp_if.in_ready  = (state_q == ACCUM) && !rst_i;
  assign accept_s         = cmp_if.in_valid && cmp_if.in_ready;

  assign cmp_if.out_valid = out_valid_q;
  assign cmp_if.lt_cnt    = lt_cnt_q;
  assign cmp_if.et_cnt    = et_cnt_q;
  assign cmp_if.gt_cnt    = gt_cnt_q;
  assign cmp_if.err_cnt   = err_cnt_q;
  assign cmp_if.n_samples = n_samples_q;
  assign cmp_if.verdict   = verdict_q;

  // Classify the incoming triple: one-hot selects an outcome, anything else is a fault.
  always_comb begin
    is_lt_s  = 1'b0;
    is_et_s  = 1'b0;
    is_gt_s  = 1'b0;
    is_err_s = 1'b0;
    case ({cmp_if.lt, cmp_if.et, cmp_if.gt})
      3'b100:  is_lt_s  = 1'b1;
      3'b010:  is_et_s  = 1'b1;
      3'b001:  is_gt_s  = 1'b1;
      default: is_err_s = 1'b1;
    endcase
  end

  // Post-update counts, window-close decision, and counter next state.
  always_comb begin
    lt_inc_s  = sat_inc(lt_q,  accept_s && is_lt_s);
    et_inc_s  = sat_inc(et_q,  accept_s && is_et_s);
    gt_inc_s  = sat_inc(gt_q,  accept_s && is_gt_s);
    err_inc_s = sat_inc(err_q, accept_s && is_err_s);
    n_inc_s   = sat_inc(n_q,   accept_s);
    report_s  = (state_q == ACCUM) &&
                ((accept_s && (n_inc_s == CNT_WIN)) || (cmp_if.flush && (n_inc_s != CNT_ZERO)));
    if (report_s) begin
      lt_d  = CNT_ZERO;
      et_d  = CNT_ZERO;
      gt_d  = CNT_ZERO;
      err_d = CNT_ZERO;
      n_d   = CNT_ZERO;
    end else begin
      lt_d  = lt_inc_s;
      et_d  = et_inc_s;
      gt_d  = gt_inc_s;
      err_d = err_inc_s;
      n_d   = n_inc_s;
    end
  end

  // Next-state logic: close the window into REPORT, leave on the output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (report_s) begin
          state_d = REPORT;
        end else begin
          state_d = ACCUM;
        end
      end
      REPORT: begin
        if (out_valid_q && cmp_if.out_ready) begin
          state_d = ACCUM;
        end else begin
          state_d = REPORT;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and window counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      lt_q    <= CNT_ZERO;
      et_q    <= CNT_ZERO;
      gt_q    <= CNT_ZERO;
      err_q   <= CNT_ZERO;
      n_q     <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      lt_q    <= lt_d;
      et_q    <= et_d;
      gt_q    <= gt_d;
      err_q   <= err_d;
      n_q     <= n_d;
    end
  end

  // Summary record: snapshot on window close, held until the downstream takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      lt_cnt_q    <= CNT_ZERO;
      et_cnt_q    <= CNT_ZERO;
      gt_cnt_q    <= CNT_ZERO;
      err_cnt_q   <= CNT_ZERO;
      n_samples_q <= CNT_ZERO;
      verdict_q   <= 2'b00;
    end else if (report_s) begin
      out_valid_q <= 1'b1;
      lt_cnt_q    <= lt_inc_s;
      et_cnt_q    <= et_inc_s;
      gt_cnt_q    <= gt_inc_s;
      err_cnt_q   <= err_inc_s;
      n_samples_q <= n_inc_s;
      verdict_q   <= verdict_of(lt_inc_s, et_inc_s, gt_inc_s);
    end else if (out_valid_q && cmp_if.out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

endmodule

// File: tb/tb_compare_tally.sv
// tb_compare_tally: directed plus randomized stimulus on three compare_tally
// configurations, checked against a queue-based window model.
module tb_compare_tally;

  logic clk;
  logic rst;
  logic in_valid_s, lt_s, et_s, gt_s, flush_s, out_ready_s;
  int   sel;

  int n_checks;
  int n_fail;

  compare_tally_if #(.CW(16)) if_a ();
  compare_tally_if #(.CW(16)) if_b ();
  compare_tally_if #(.CW(2))  if_c ();

  compare_tally #(.WINDOW(4),  .CW(16)) u_a (.clk_i(clk), .rst_i(rst), .cmp_if(if_a));
  compare_tally #(.WINDOW(16), .CW(16)) u_b (.clk_i(clk), .rst_i(rst), .cmp_if(if_b));
  compare_tally #(.WINDOW(3),  .CW(2))  u_c (.clk_i(clk), .rst_i(rst), .cmp_if(if_c));

  assign if_a.in_valid = in_valid_s && (sel == 0);
  assign if_b.in_valid = in_valid_s && (sel == 1);
  assign if_c.in_valid = in_valid_s && (sel == 2);
  assign if_a.flush = flush_s && (sel == 0);
  assign if_b.flush = flush_s && (sel == 1);
  assign if_c.flush = flush_s && (sel == 2);
  assign if_a.lt = lt_s;  assign if_a.et = et_s;  assign if_a.gt = gt_s;
  assign if_b.lt = lt_s;  assign if_b.et = et_s;  assign if_b.gt = gt_s;
  assign if_c.lt = lt_s;  assign if_c.et = et_s;  assign if_c.gt = gt_s;
  assign if_a.out_ready = out_ready_s;
  assign if_b.out_ready = out_ready_s;
  assign if_c.out_ready = out_ready_s;

  logic        obs_in_ready, obs_out_valid;
  logic [15:0] obs_lt, obs_et, obs_gt, obs_err, obs_n;
  logic [1:0]  obs_vd;

  // Route the selected instance's outputs to a common observation set.
  always_comb begin
    obs_in_ready = 1'b0; obs_out_valid = 1'b0;
    obs_lt = 16'd0; obs_et = 16'd0; obs_gt = 16'd0; obs_err = 16'd0; obs_n = 16'd0;
    obs_vd = 2'b00;
    case (sel)
      0: begin
        obs_in_ready = if_a.in_ready; obs_out_valid = if_a.out_valid;
        obs_lt = if_a.lt_cnt; obs_et = if_a.et_cnt; obs_gt = if_a.gt_cnt;
        obs_err = if_a.err_cnt; obs_n = if_a.n_samples; obs_vd = if_a.verdict;
      end
      1: begin
        obs_in_ready = if_b.in_ready; obs_out_valid = if_b.out_valid;
        obs_lt = if_b.lt_cnt; obs_et = if_b.et_cnt; obs_gt = if_b.gt_cnt;
        obs_err = if_b.err_cnt; obs_n = if_b.n_samples; obs_vd = if_b.verdict;
      end
      2: begin
        obs_in_ready = if_c.in_ready; obs_out_valid = if_c.out_valid;
        obs_lt = {14'd0, if_c.lt_cnt}; obs_et = {14'd0, if_c.et_cnt};
        obs_gt = {14'd0, if_c.gt_cnt}; obs_err = {14'd0, if_c.err_cnt};
        obs_n = {14'd0, if_c.n_samples}; obs_vd = if_c.verdict;
      end
      default: begin
        obs_in_ready = 1'b0;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the current window is a list of accepted triples.
  logic [2:0] mq[$];
  bit         m_rep;
  int         win, cap;
  int         e_lt, e_et, e_gt, e_err, e_n, e_vd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  function automatic int clip(input int v);
    return (v > cap) ? cap : v;
  endfunction

  task automatic build_rec();
    int a, b, c, e, m, w;
    a = 0; b = 0; c = 0; e = 0;
    foreach (mq[i]) begin
      case (mq[i])
        3'b100:  a++;
        3'b010:  b++;
        3'b001:  c++;
        default: e++;
      endcase
    end
    e_lt = clip(a); e_et = clip(b); e_gt = clip(c); e_err = clip(e);
    e_n = clip(mq.size());
    m = e_lt;
    if (e_et > m) m = e_et;
    if (e_gt > m) m = e_gt;
    w = int'(e_lt == m) + int'(e_et == m) + int'(e_gt == m);
    if (m == 0 || w != 1) e_vd = 0;
    else if (e_lt == m)   e_vd = 1;
    else if (e_et == m)   e_vd = 2;
    else                  e_vd = 3;
  endtask

  task automatic step(input bit v, input logic [2:0] t, input bit fl, input bit ordy);
    in_valid_s = v; {lt_s, et_s, gt_s} = t; flush_s = fl; out_ready_s = ordy;
    #1;
    check_val("in_ready", 32'(obs_in_ready), 32'(!m_rep));
    check_val("out_valid", 32'(obs_out_valid), 32'(m_rep));
    if (m_rep) begin
      check_val("lt_cnt", 32'(obs_lt), e_lt);
      check_val("et_cnt", 32'(obs_et), e_et);
      check_val("gt_cnt", 32'(obs_gt), e_gt);
      check_val("err_cnt", 32'(obs_err), e_err);
      check_val("n_samples", 32'(obs_n), e_n);
      check_val("verdict", 32'(obs_vd), e_vd);
    end
    if (!m_rep) begin
      if (v) mq.push_back(t);
      if ((v && mq.size() == win) || (fl && mq.size() >= 1)) begin
        build_rec();
        mq.delete();
        m_rep = 1'b1;
      end
    end else if (ordy) begin
      m_rep = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid_s = 1'b0; flush_s = 1'b0; out_ready_s = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(obs_in_ready), 32'd0);
    check_val("rst_out_valid", 32'(obs_out_valid), 32'd0);
    check_val("rst_counts", 32'(obs_lt | obs_et | obs_gt | obs_err | obs_n), 32'd0);
    check_val("rst_verdict", 32'(obs_vd), 32'd0);
    mq.delete();
    m_rep = 1'b0;
    rst = 1'b0;
  endtask

  task automatic set_sel(input int s);
    sel = s;
    win = (s == 0) ? 4 : (s == 1) ? 16 : 3;
    cap = (s == 2) ? 3 : 65535;
    do_reset();
  endtask

  function automatic logic [2:0] rand_trip();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 3)      return 3'b100;
    else if (r < 6) return 3'b010;
    else if (r < 8) return 3'b001;
    else            return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid_s = 1'b0; lt_s = 1'b0; et_s = 1'b0; gt_s = 1'b0;
    flush_s = 1'b0; out_ready_s = 1'b0;
    @(posedge clk);
    #1;

    // WINDOW=4: full window lt, lt, gt, et.
    set_sel(0);
    step(1'b1, 3'b100, 1'b0, 1'b1); step(1'b1, 3'b100, 1'b0, 1'b1);
    step(1'b1, 3'b001, 1'b0, 1'b1); step(1'b1, 3'b010, 1'b0, 1'b1);
    check_val("fw_valid", 32'(obs_out_valid), 32'd1);
    check_val("fw_lt", 32'(obs_lt), 32'd2);
    check_val("fw_gt", 32'(obs_gt), 32'd1);
    check_val("fw_et", 32'(obs_et), 32'd1);
    check_val("fw_err", 32'(obs_err), 32'd0);
    check_val("fw_n", 32'(obs_n), 32'd4);
    check_val("fw_verdict", 32'(obs_vd), 32'd1);
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // Tie and malformed triples.
    step(1'b1, 3'b001, 1'b0, 1'b1); step(1'b1, 3'b010, 1'b0, 1'b1);
    step(1'b1, 3'b000, 1'b0, 1'b1); step(1'b1, 3'b110, 1'b0, 1'b1);
    check_val("tie_gt", 32'(obs_gt), 32'd1);
    check_val("tie_et", 32'(obs_et), 32'd1);
    check_val("tie_err", 32'(obs_err), 32'd2);
    check_val("tie_n", 32'(obs_n), 32'd4);
    check_val("tie_verdict", 32'(obs_vd), 32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // Backpressure: hold out_ready low for 5 cycles while inputs keep offering.
    for (int i = 0; i < 4; i++) step(1'b1, 3'b100, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 3'b010, 1'b0, 1'b1);
    check_val("bp_next_et", 32'(obs_et), 32'd4);
    check_val("bp_next_lt", 32'(obs_lt), 32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // Reset after two accepts: the next report sees only post-reset samples.
    step(1'b1, 3'b100, 1'b0, 1'b1); step(1'b1, 3'b100, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 1'b0, 1'b1);
    check_val("rmid_gt", 32'(obs_gt), 32'd4);
    check_val("rmid_lt", 32'(obs_lt), 32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // Reset while a summary is pending.
    for (int i = 0; i < 4; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // WINDOW=16: flush with nothing counted produces no report.
    set_sel(1);
    step(1'b0, 3'b000, 1'b1, 1'b1);
    check_val("flush_empty", 32'(obs_out_valid), 32'd0);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010, 1'b0, 1'b1);
    step(1'b0, 3'b000, 1'b1, 1'b1);
    check_val("flush_n", 32'(obs_n), 32'd3);
    check_val("flush_et", 32'(obs_et), 32'd3);
    check_val("flush_verdict", 32'(obs_vd), 32'd2);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, rand_trip(), 1'b0, 1'b1);
    step(1'b1, 3'b100, 1'b1, 1'b1);
    check_val("flush16_n", 32'(obs_n), 32'd16);
    step(1'b0, 3'b000, 1'b1, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // CW=2, WINDOW=3: saturating counters.
    set_sel(2);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b100, 1'b0, 1'b1);
    check_val("sat_lt", 32'(obs_lt), 32'd3);
    check_val("sat_n", 32'(obs_n), 32'd3);
    step(1'b0, 3'b000, 1'b0, 1'b1);

    // Randomized traffic on each configuration.
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 149) == 0) begin
          do_reset();
        end else begin
          step(($urandom_range(0, 3) != 0), rand_trip(), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) != 0));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compare_tally.md
# compare_tally

Downstream consumer of the 32-bit magnitude comparator's `lt`/`et`/`gt` flags. It accepts one flag triple per handshake, counts the outcomes over a window of `WINDOW` samples, and then presents a summary record through a valid/ready output port. The summary holds the three outcome counts, a malformed-flag count, the sample count and a dominant-outcome verdict. The block also flags comparator faults: any triple that is not one-hot counts as an error.

## Interface
- `WINDOW`, default 16: samples per report; legal range 1..2^CW-1.
- `CW`, default 16: width of every count output.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  flag triple valid.
- `in_ready`  out  1  block can accept a triple.
- `lt`, `et`, `gt`  in  1 each  comparator outcome flags.
- `flush`  in  1  single-cycle request to report a partial window.
- `out_valid`  out  1  summary record valid.
- `out_ready`  in  1  downstream accepts the summary.
- `lt_cnt`, `et_cnt`, `gt_cnt`  out  CW each  outcome counts for the window.
- `err_cnt`  out  CW  count of triples that were not one-hot.
- `n_samples`  out  CW  triples counted in this report.
- `verdict`  out  2  dominant outcome: 01 = lt, 10 = et, 11 = gt, 00 = tie or empty.

## Operation
- The block has two states: ACCUM and REPORT. Reset enters ACCUM with all internal counters at 0.
- **Reset values:**
  - `out_valid` = 0.
  - All count outputs = 0.
  - `verdict` = 00.
  - `in_ready` = 0 while `rst` is high. `in_ready` = (state == ACCUM) otherwise.
- **Accept** occurs when `in_valid && in_ready`.
  - The triple is classified:
    - Exactly one of `lt`/`et`/`gt` high: the matching internal counter increments.
    - Otherwise (000, 110, 111, etc.): the internal error counter increments.
  - The sample counter increments on every accept.
- **All internal counters saturate** at 2^CW-1. They never wrap.
- **ACCUM → REPORT** occurs when either condition holds:
  - An accept brings the sample count to `WINDOW`.
  - `flush` is high and the post-update sample count is ≥ 1.
- **Snapshot on entering REPORT:**
  - The output registers load the post-update counts, so a sample accepted in the transition cycle is included.
  - `out_valid` is set to 1.
  - The internal counters clear to 0 in that same cycle.
- **Verdict** is computed from the snapshot counts:
  - It names the largest of `lt_cnt`, `et_cnt`, `gt_cnt` only when that maximum is strictly greater than the other two.
  - A tie for the maximum, or all three zero, gives 00.
  - `err_cnt` does not affect the verdict.
- **REPORT behaviour:**
  - `in_ready` = 0.
  - All outputs are held stable until `out_valid && out_ready`.
  - On that handshake: `out_valid` clears next cycle, state returns to ACCUM, and `in_ready` = 1 next cycle.
  - The count outputs keep their last values after the handshake (don't-care while `out_valid` is 0). The bench must not check them then.
- **Flush rules:**
  - `flush` is ignored in REPORT.
  - `flush` is ignored in ACCUM when the sample count is 0 and no accept occurs that cycle.
- **Flag sampling:** `lt`/`et`/`gt` are sampled only on an accept. Their values outside an accept are don't-care.

## Timing
- Input side: one triple per cycle maximum; sustained throughput is `WINDOW` triples per `WINDOW`+1+k cycles, where k = cycles `out_ready` stays low.
- Latency: `out_valid` rises the cycle after the accept that completes the window, or after the `flush` cycle.
- Minimum REPORT occupancy is 1 cycle (`out_ready` held high). Input acceptance resumes the cycle after the output handshake, so there is no input/output overlap.
- `out_valid` must not drop while `out_ready` is low. The payload must not change while `out_valid` is high.
- `in_ready` never depends combinationally on `in_valid`. `out_valid` never depends on `out_ready`.
- `rst` mid-window or mid-REPORT: the next cycle is ACCUM with zero counts and `out_valid` = 0. A pending summary is discarded.
- Simultaneous final accept and `flush`: one report is produced, containing `WINDOW` samples.

## Test plan
- **Full window:** `WINDOW`=4, `out_ready`=1; accept lt, lt, gt, et.
  - Expected: `out_valid` one cycle after the 4th accept, with `lt_cnt`=2, `gt_cnt`=1, `et_cnt`=1, `err_cnt`=0, `n_samples`=4, `verdict`=01.
- **Tie and errors:** `WINDOW`=4; accept gt, et, 000, 110.
  - Expected: `gt_cnt`=1, `et_cnt`=1, `err_cnt`=2, `n_samples`=4, `verdict`=00.
- **Backpressure:** complete a window, then hold `out_ready`=0 for 5 cycles.
  - Expected: `in_ready`=0 and `out_valid`=1 with a stable payload for all 5 cycles.
  - Expected: after `out_ready`=1, `out_valid`=0 and `in_ready`=1 the next cycle, and the next report starts from zero counts.
- **Flush:** `WINDOW`=16; accept et ×3, then pulse `flush`.
  - Expected: `n_samples`=3, `et_cnt`=3, `verdict`=10.
  - Also: a `flush` pulse with zero samples produces no `out_valid`.
  - Also: `flush` coinciding with the 16th accept produces one report with `n_samples`=16.
- **Saturation:** `CW`=2, `WINDOW`=3, stimulus lt ×3.
  - Expected: `lt_cnt`=3, `n_samples`=3.
- **Reset mid-operation:**
  - Assert `rst` after 2 accepts: the following report counts only post-reset samples.
  - Assert `rst` during REPORT: `out_valid` drops the next cycle and all outputs read 0.
